elevator_scheduler: RTL and testbench
=====================================

# elevator_scheduler

Sequential controller for the 4-floor elevator car. It latches floor requests from the four call buttons into a pending set and drives the motor and door outputs. It schedules service in SCAN order: keep the current direction while requests lie ahead, then reverse. It sits between the raw call buttons and the motor/door drivers, and replaces one-shot priority encoding of button presses with persistent, multi-request scheduling.

## Interface
- TRAVEL_CYCLES, default 8: clock cycles to move one floor; legal range is 1 or more.
- DOOR_CYCLES, default 6: clock cycles the door stays open; legal range is 1 or more.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- button1..button4  input  1 each  level call requests for floors 0..3; several may be asserted in the same cycle.
- current_floor  output  2  floor the car is at, or floor last passed.
- motor_up  output  1  car moving up.
- motor_down  output  1  car moving down.
- door_open  output  1  door open at current_floor.
- pending  output  4  latched requests; bit i is floor i.
- busy  output  1  state is not IDLE.

## Operation
- Reset values:
  - current_floor=0, pending=0, all outputs 0.
  - State is IDLE, dir_up=1, travel and door counters are 0.
- Request latching, every cycle:
  - pending[i] is set when button(i+1) is high.
  - Exception: no set for the current floor while in DOOR_OPEN. Instead, the door timer restarts.
  - A bit clears only on entry to DOOR_OPEN at that floor.
  - Set and clear in the same cycle for the same floor: clear wins.
- Helper terms: "above" means any pending bit > current_floor; "below" means any pending bit < current_floor.
- IDLE, evaluated in priority order:
  - pending[current_floor] set: go to DOOR_OPEN.
  - dir_up and above: go to MOVE_UP.
  - below: go to MOVE_DOWN and set dir_up=0.
  - above: go to MOVE_UP and set dir_up=1.
  - Otherwise stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - motor_up or motor_down is asserted for the whole state.
  - The travel counter runs 0..TRAVEL_CYCLES-1. On the final count current_floor moves ±1 and the counter returns to 0.
  - On arrival: if pending[new floor] is set, go to DOOR_OPEN. Else if requests remain ahead, stay in the same move state. Else go to IDLE.
  - A request at a floor being passed is served only if latched before the arrival cycle.
  - current_floor never wraps. MOVE_UP is never entered at floor 3 and MOVE_DOWN is never entered at floor 0.
- DOOR_OPEN:
  - door_open=1.
  - The door counter runs 0..DOOR_CYCLES-1, then the state goes to IDLE.
  - The current-floor button restarts the counter at 0.
- motor_up, motor_down and door_open are mutually exclusive; at most one is high in any cycle.
- All outputs are registered.

## Timing
- Button high at edge N: pending bit visible after edge N.
- IDLE decision uses pending as registered; the first move or door cycle follows the next edge, so IDLE to motion takes 1 cycle.
- One-floor trip lasts exactly TRAVEL_CYCLES cycles with motor asserted. door_open rises the cycle after the arrival edge.
- Door dwell lasts DOOR_CYCLES cycles when no re-press occurs.
- Reset assertion mid-move or mid-door forces all reset values immediately, asynchronously. Pending requests are discarded.

## Configuration
- EMERGENCY_STOP_EN defined:
  - Adds input estop (1 bit, active-high).
  - While estop=1: motor outputs are forced to 0, the travel counter holds, and the door stays in its current state. Buttons still latch.
  - On release, operation resumes from the held count with the same state.
- EMERGENCY_STOP_EN undefined: no estop port and no hold logic.

## Test plan
- Reset, then button3 for 1 cycle at floor 0, TRAVEL_CYCLES=8:
  - Expect motor_up for 16 cycles, current_floor stepping 1 then 2.
  - Then door_open for 6 cycles, pending[2] cleared, return to IDLE.
- button2 and button4 asserted in the same cycle at floor 0:
  - Expect stop at floor 1 with door_open.
  - Then continue up to floor 3 with no reversal.
- Car moving up between floor 1 and 2 with pending floor 3; button1 pressed:
  - Expect floor 3 served first, then MOVE_DOWN to floor 0.
- During DOOR_OPEN at floor 2, button3 re-pressed at door count 4:
  - Expect dwell extended to 4+6 cycles and pending[2] never set.
- rst_n low mid-travel at count 5: expect immediate zero outputs, current_floor=0, pending=0.
- With EMERGENCY_STOP_EN, estop=1 for 10 cycles during a move: expect motor low, counter frozen, and the trip completing 10 cycles late.

Source files
------------

// File: rtl/elevator_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_scheduler
//
// Purpose:
//   Request latching and SCAN scheduling for a 4-floor elevator car.
//   Call buttons are latched into a persistent pending set. The car keeps
//   its direction while requests lie ahead and reverses when none remain.
//   The motor and door drivers are fed from registered outputs.
//
// Parameters:
//   TRAVEL_CYCLES  clock cycles to move one floor (>= 1)
//   DOOR_CYCLES    clock cycles the door stays open (>= 1)
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   button1..4     level call requests for floors 0..3
//   estop          emergency stop, active-high (EMERGENCY_STOP_EN builds only)
//   current_floor  floor the car is at, or the floor it last passed
//   motor_up       car moving up
//   motor_down     car moving down
//   door_open      door open at current_floor
//   pending        latched requests, bit i = floor i
//   busy           controller is not idle
//
// Build option:
//   EMERGENCY_STOP_EN  adds the estop input. While estop is high the FSM and
//                      its counters freeze and the motor outputs drop; buttons
//                      keep latching. Releasing estop resumes from the frozen
//                      state and count.
// -----------------------------------------------------------------------------
module elevator_scheduler #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
`ifdef EMERGENCY_STOP_EN
    input  logic       estop,
`endif
    output logic [1:0] current_floor,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic [3:0] pending,
    output logic       busy
);

    localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TCW-1:0] TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);
    localparam logic [DCW-1:0] DOOR_LAST   = DCW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic any_above(input logic [3:0] req, input logic [1:0] flr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (req[i] && (2'(i) > flr)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic logic any_below(input logic [3:0] req, input logic [1:0] flr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (req[i] && (2'(i) < flr)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic logic [3:0] floor_onehot(input logic [1:0] flr);
        return 4'b0001 << flr;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e           state_q,      state_d;
    logic             dir_up_q,     dir_up_d;
    logic [1:0]       floor_q,      floor_d;
    logic [3:0]       pending_q,    pending_d;
    logic [TCW-1:0]   travel_q,     travel_d;
    logic [DCW-1:0]   door_cnt_q,   door_cnt_d;
    logic             motor_up_q,   motor_up_d;
    logic             motor_down_q, motor_down_d;
    logic             door_open_q,  door_open_d;
    logic             busy_q,       busy_d;

    logic [3:0]       btn;
    logic [3:0]       clr;
    logic [3:0]       set_mask;
    logic [1:0]       next_floor;
    logic             run;

    assign btn = {button4, button3, button2, button1};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        dir_up_d   = dir_up_q;
        floor_d    = floor_q;
        travel_d   = travel_q;
        door_cnt_d = door_cnt_q;
        clr        = 4'b0000;
        next_floor = floor_q;
        run        = 1'b1;

        case (state_q)
            IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d    = DOOR_OPEN;
                    door_cnt_d = '0;
                    clr        = floor_onehot(floor_q);
                end else if (dir_up_q && any_above(pending_q, floor_q)) begin
                    state_d  = MOVE_UP;
                    travel_d = '0;
                end else if (any_below(pending_q, floor_q)) begin
                    state_d  = MOVE_DOWN;
                    dir_up_d = 1'b0;
                    travel_d = '0;
                end else if (any_above(pending_q, floor_q)) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                    travel_d = '0;
                end
            end

            MOVE_UP: begin
                if (travel_q == TRAVEL_LAST) begin
                    next_floor = floor_q + 2'd1;
                    floor_d    = next_floor;
                    travel_d   = '0;
                    // Arrival decision uses the registered pending set, so a
                    // button pressed on the arrival edge is not served here.
                    if (pending_q[next_floor]) begin
                        state_d    = DOOR_OPEN;
                        door_cnt_d = '0;
                        clr        = floor_onehot(next_floor);
                    end else if (!any_above(pending_q, next_floor)) begin
                        state_d = IDLE;
                    end
                end else begin
                    travel_d = travel_q + TCW'(1);
                end
            end

            MOVE_DOWN: begin
                if (travel_q == TRAVEL_LAST) begin
                    next_floor = floor_q - 2'd1;
                    floor_d    = next_floor;
                    travel_d   = '0;
                    if (pending_q[next_floor]) begin
                        state_d    = DOOR_OPEN;
                        door_cnt_d = '0;
                        clr        = floor_onehot(next_floor);
                    end else if (!any_below(pending_q, next_floor)) begin
                        state_d = IDLE;
                    end
                end else begin
                    travel_d = travel_q - TCW'(0) + TCW'(1);
                end
            end

            DOOR_OPEN: begin
                // A press at the open floor extends the dwell instead of
                // re-latching the request.
                if (btn[floor_q]) begin
                    door_cnt_d = '0;
                end else if (door_cnt_q == DOOR_LAST) begin
                    state_d    = IDLE;
                    door_cnt_d = '0;
                end else begin
                    door_cnt_d = door_cnt_q + DCW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef EMERGENCY_STOP_EN
        // Freeze the whole scheduler; only request latching continues.
        if (estop) begin
            run        = 1'b0;
            state_d    = state_q;
            dir_up_d   = dir_up_q;
            floor_d    = floor_q;
            travel_d   = travel_q;
            door_cnt_d = door_cnt_q;
            clr        = 4'b0000;
        end
`endif

        // The open floor is masked from latching; clearing beats setting.
        set_mask  = (state_q == DOOR_OPEN) ? ~floor_onehot(floor_q) : 4'b1111;
        pending_d = (pending_q | (btn & set_mask)) & ~clr;

        // Outputs are decoded from the next state so they change on the same
        // edge as the state register and stay mutually exclusive.
        motor_up_d   = (state_d == MOVE_UP)   && run;
        motor_down_d = (state_d == MOVE_DOWN) && run;
        door_open_d  = (state_d == DOOR_OPEN);
        busy_d       = (state_d != IDLE);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dir_up_q     <= 1'b1;
            floor_q      <= 2'd0;
            pending_q    <= 4'b0000;
            travel_q     <= '0;
            door_cnt_q   <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_up_q     <= dir_up_d;
            floor_q      <= floor_d;
            pending_q    <= pending_d;
            travel_q     <= travel_d;
            door_cnt_q   <= door_cnt_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            door_open_q  <= door_open_d;
            busy_q       <= busy_d;
        end
    end

    assign current_floor = floor_q;
    assign motor_up      = motor_up_q;
    assign motor_down    = motor_down_q;
    assign door_open     = door_open_q;
    assign pending       = pending_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
module tb_elevator_scheduler;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn   = 4'b0000;
`ifdef EMERGENCY_STOP_EN
    logic       estop = 1'b0;
`endif
    logic [1:0] current_floor;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic [3:0] pending;
    logic       busy;

    elevator_scheduler #(
        .TRAVEL_CYCLES(8),
        .DOOR_CYCLES  (6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .button1      (btn[0]),
        .button2      (btn[1]),
        .button3      (btn[2]),
        .button4      (btn[3]),
`ifdef EMERGENCY_STOP_EN
        .estop        (estop),
`endif
        .current_floor(current_floor),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .door_open    (door_open),
        .pending      (pending),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int up_cnt, dn_cnt, door_cnt, excl_bad;
    int served[$];
    int mv_floor[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int served_at(input int i);
        return (i < served.size()) ? served[i] : -1;
    endfunction

    function automatic int mvf(input int i);
        return (i < mv_floor.size()) ? mv_floor[i] : -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        btn   = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive buttons for exactly one rising edge; returns on the next negedge.
    task automatic press(input logic [3:0] b);
        btn = b;
        @(negedge clk);
        btn = 4'b0000;
    endtask

    task automatic wait_floor(input int f, input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (int'(current_floor) == f) break;
        end
        check(tag, current_floor, f);
    endtask

    // Run until the car is idle with nothing pending, tallying activity.
    task automatic collect(input int max_cyc, input string tag);
        bit   started;
        bit   done;
        logic prev_door;
        started   = 1'b0;
        done      = 1'b0;
        prev_door = door_open;
        up_cnt    = 0;
        dn_cnt    = 0;
        door_cnt  = 0;
        excl_bad  = 0;
        served.delete();
        mv_floor.delete();
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (busy) started = 1'b1;
            if (motor_up) begin
                up_cnt++;
                mv_floor.push_back(int'(current_floor));
            end
            if (motor_down) dn_cnt++;
            if (door_open) begin
                door_cnt++;
                if (!prev_door) served.push_back(int'(current_floor));
            end
            if (int'(motor_up) + int'(motor_down) + int'(door_open) > 1) excl_bad++;
            prev_door = door_open;
            if (started && !busy && pending == 4'b0000) begin
                done = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_excl"}, excl_bad, 0);
    endtask

    initial begin
        int dcnt;

        // Reset values
        #1;
        check("rst_floor", current_floor, 0);
        check("rst_up", motor_up, 0);
        check("rst_down", motor_down, 0);
        check("rst_door", door_open, 0);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 0);

        // Single request two floors up
        do_reset();
        press(4'b0100);
        check("t1_latch", pending, 4'b0100);
        check("t1_idle_gap", motor_up, 0);
        collect(200, "t1");
        check("t1_up_cycles", up_cnt, 16);
        check("t1_floor_i0", mvf(0), 0);
        check("t1_floor_i7", mvf(7), 0);
        check("t1_floor_i8", mvf(8), 1);
        check("t1_floor_i15", mvf(15), 1);
        check("t1_door_cycles", door_cnt, 6);
        check("t1_nserved", served.size(), 1);
        check("t1_served0", served_at(0), 2);
        check("t1_final_floor", current_floor, 2);
        check("t1_pending", pending, 0);
        check("t1_busy", busy, 0);

        // Two requests in the same cycle: stop at 1, continue to 3
        do_reset();
        press(4'b1010);
        check("t2_latch", pending, 4'b1010);
        collect(300, "t2");
        check("t2_nserved", served.size(), 2);
        check("t2_served0", served_at(0), 1);
        check("t2_served1", served_at(1), 3);
        check("t2_up_cycles", up_cnt, 24);
        check("t2_no_reverse", dn_cnt, 0);
        check("t2_door_cycles", door_cnt, 12);
        check("t2_final_floor", current_floor, 3);

        // Request behind the car while moving up: finish upward sweep first
        do_reset();
        press(4'b1000);
        wait_floor(1, "t3_reach1");
        repeat (3) @(negedge clk);
        press(4'b0001);
        collect(400, "t3");
        check("t3_nserved", served.size(), 2);
        check("t3_served0", served_at(0), 3);
        check("t3_served1", served_at(1), 0);
        check("t3_down_cycles", dn_cnt, 24);
        check("t3_final_floor", current_floor, 0);

        // Request latched on the arrival edge of its floor is passed over
        do_reset();
        press(4'b1000);
        wait_floor(1, "t4_reach1");
        repeat (7) @(negedge clk);
        press(4'b0100);
        check("t4_arr_floor", current_floor, 2);
        check("t4_still_up", motor_up, 1);
        check("t4_pending", pending, 4'b1100);
        collect(400, "t4");
        check("t4_served0", served_at(0), 3);
        check("t4_served1", served_at(1), 2);
        check("t4_down_cycles", dn_cnt, 8);

        // Re-press at the open floor extends dwell and is not latched
        do_reset();
        press(4'b0100);
        dcnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (door_open) break;
            @(negedge clk);
        end
        check("t5_door_reached", door_open, 1);
        dcnt = 1;
        repeat (3) begin
            @(negedge clk);
            if (door_open) dcnt++;
        end
        press(4'b0100);
        if (door_open) dcnt++;
        check("t5_no_latch", pending, 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!door_open) break;
            dcnt++;
            if (pending != 4'b0000) check("t5_pending_dwell", pending, 0);
        end
        check("t5_dwell", dcnt, 10);
        check("t5_idle", busy, 0);

        // Asynchronous reset mid-travel
        do_reset();
        press(4'b1000);
        wait_floor(1, "t6_reach1");
        repeat (5) @(negedge clk);
        check("t6_pre_pending", pending, 4'b1000);
        check("t6_pre_motor", motor_up, 1);
        rst_n = 1'b0;
        #1;
        check("t6_floor", current_floor, 0);
        check("t6_pending", pending, 0);
        check("t6_up", motor_up, 0);
        check("t6_busy", busy, 0);
        check("t6_door", door_open, 0);

        // Call at the floor the car sits on opens the door without motion
        do_reset();
        press(4'b0001);
        collect(100, "t7");
        check("t7_served0", served_at(0), 0);
        check("t7_door_cycles", door_cnt, 6);
        check("t7_motion", up_cnt + dn_cnt, 0);

`ifdef EMERGENCY_STOP_EN
        // Emergency stop for 10 cycles during a one-floor trip
        do_reset();
        press(4'b0010);
        begin
            int span;
            int low;
            span = 0;
            low  = 0;
            @(negedge clk);
            check("t8_motor_start", motor_up, 1);
            repeat (3) begin
                @(negedge clk);
                span++;
            end
            estop = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                span++;
                if (!motor_up) low++;
            end
            estop = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (door_open) break;
                @(negedge clk);
                span++;
            end
            check("t8_motor_low", low, 10);
            check("t8_trip_span", span, 18);
            check("t8_floor", current_floor, 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
